// File: rtl/conv_pkg.sv
// Shared types and saturation limits for the convolution accumulate/ReLU datapath.
package conv_pkg;

   typedef enum logic [1:0] {ACC, BIAS, QUANT, HOLD} state_t;

   localparam int unsigned SHIFT_W = 5;

   // Signed limits of a w-bit accumulator, evaluated at elaboration time.
   function automatic longint sat_hi(input int unsigned w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_lo(input int unsigned w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/relu_requant.sv
// Combinational requantisation: arithmetic right shift, ReLU, clamp to unsigned pDATA_W.
module relu_requant
   import conv_pkg::*;
#(
   parameter int unsigned pDATA_W = 8,
   parameter int unsigned pACC_W  = 32
) (
   input  logic [pACC_W-1:0]  acc,
   input  logic [SHIFT_W-1:0] shift,
   output logic [pDATA_W-1:0] data_c,
   output logic               clip_c
);

   localparam logic signed [pACC_W-1:0] OUT_MAX = pACC_W'((64'd1 << pDATA_W) - 64'd1);

   logic signed [pACC_W-1:0] shifted;

   always_comb begin
      shifted = $signed(acc) >>> shift;
      data_c  = '0;
      clip_c  = 1'b0;
      if (shifted[pACC_W-1]) begin
         data_c = '0;
      end else if (shifted > OUT_MAX) begin
         data_c = '1;
         clip_c = 1'b1;
      end else begin
         data_c = shifted[pDATA_W-1:0];
      end
   end

endmodule

// File: rtl/conv_acc_relu.sv
// Accumulates pCH_NUM partial sums, adds bias with rounding, requantises through ReLU
// and holds the activation until downstream accepts it.
module conv_acc_relu
   import conv_pkg::*;
#(
   parameter int unsigned pDATA_W = 8,
   parameter int unsigned pCH_NUM = 16,
   parameter int unsigned pACC_W  = 32
) (
   input  logic                 iclk,
   input  logic                 irst,
   input  logic                 iclear,
   input  logic                 ivalid,
   output logic                 iready,
   input  logic [2*pDATA_W-1:0] idata,
   input  logic [pACC_W-1:0]    ibias,
   input  logic [SHIFT_W-1:0]   ishift,
   output logic                 ovalid,
   input  logic                 oready,
   output logic [pDATA_W-1:0]   odata,
   output logic                 oclip
);

   localparam int unsigned CNT_W = (pCH_NUM > 1) ? $clog2(pCH_NUM) : 1;
   localparam int unsigned SUM_W = pACC_W + 2;
   localparam logic signed [SUM_W-1:0] SAT_HI   = SUM_W'(sat_hi(pACC_W));
   localparam logic signed [SUM_W-1:0] SAT_LO   = SUM_W'(sat_lo(pACC_W));
   localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(pCH_NUM - 1);

   state_t                    state, state_next;
   logic signed [pACC_W-1:0]  acc, acc_next;
   logic signed [pACC_W-1:0]  bias_q, bias_next;
   logic [SHIFT_W-1:0]        shift_q, shift_next;
   logic [CNT_W-1:0]          cnt, cnt_next;
   logic                      ovalid_next, oclip_next, iready_next;
   logic [pDATA_W-1:0]        odata_next;
   logic                      beat;
   logic signed [SUM_W-1:0]   rnd, sum_beat, sum_bias;
   logic [pDATA_W-1:0]        rq_data_c;
   logic                      rq_clip_c;

   function automatic logic signed [pACC_W-1:0] sat(input logic signed [SUM_W-1:0] v);
      if (v > SAT_HI)      return SAT_HI[pACC_W-1:0];
      else if (v < SAT_LO) return SAT_LO[pACC_W-1:0];
      else                 return v[pACC_W-1:0];
   endfunction

   relu_requant #(
      .pDATA_W (pDATA_W),
      .pACC_W  (pACC_W)
   ) u_relu_requant (
      .acc    (acc),
      .shift  (shift_q),
      .data_c (rq_data_c),
      .clip_c (rq_clip_c)
   );

   // Next-state and datapath; iclear overrides everything after the case.
   always_comb begin
      state_next  = state;
      acc_next    = acc;
      cnt_next    = cnt;
      bias_next   = bias_q;
      shift_next  = shift_q;
      ovalid_next = ovalid;
      odata_next  = odata;
      oclip_next  = oclip;
      beat        = ivalid && iready && !iclear;
      rnd         = (shift_q != '0) ? (SUM_W'(1) <<< (shift_q - SHIFT_W'(1))) : '0;
      sum_beat    = SUM_W'(acc) + SUM_W'($signed(idata));
      sum_bias    = SUM_W'(acc) + SUM_W'(bias_q) + rnd;

      case (state)
         ACC: begin
            if (beat) begin
               if (cnt == '0) begin
                  acc_next   = pACC_W'($signed(idata));
                  bias_next  = $signed(ibias);
                  shift_next = ishift;
               end else begin
                  acc_next = sat(sum_beat);
               end
               if (cnt == CNT_LAST) begin
                  cnt_next   = '0;
                  state_next = BIAS;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
         end
         BIAS: begin
            acc_next   = sat(sum_bias);
            state_next = QUANT;
         end
         QUANT: begin
            odata_next  = rq_data_c;
            oclip_next  = rq_clip_c;
            ovalid_next = 1'b1;
            state_next  = HOLD;
         end
         HOLD: begin
            if (oready) begin
               ovalid_next = 1'b0;
               state_next  = ACC;
            end
         end
         default: state_next = ACC;
      endcase

      if (iclear) begin
         state_next  = ACC;
         cnt_next    = '0;
         acc_next    = '0;
         ovalid_next = 1'b0;
         oclip_next  = 1'b0;
      end

      iready_next = (state_next == ACC);
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         state   <= ACC;
         acc     <= '0;
         cnt     <= '0;
         bias_q  <= '0;
         shift_q <= '0;
         ovalid  <= 1'b0;
         odata   <= '0;
         oclip   <= 1'b0;
         iready  <= 1'b1;
      end else begin
         state   <= state_next;
         acc     <= acc_next;
         cnt     <= cnt_next;
         bias_q  <= bias_next;
         shift_q <= shift_next;
         ovalid  <= ovalid_next;
         odata   <= odata_next;
         oclip   <= oclip_next;
         iready  <= iready_next;
      end
   end

endmodule

// File: tb/tb_conv_acc_relu.sv
// Directed scoreboard bench for conv_acc_relu with four channels per group.
module tb_conv_acc_relu;

   localparam int unsigned DW = 8;
   localparam int unsigned CH = 4;
   localparam int unsigned AW = 32;

   logic          iclk = 1'b0;
   logic          irst, iclear, ivalid, iready, oready, ovalid, oclip;
   logic [2*DW-1:0] idata;
   logic [AW-1:0] ibias;
   logic [4:0]    ishift;
   logic [DW-1:0] odata;

   logic [8:0]    exp_q[$];
   int            n_chk  = 0;
   int            n_pass = 0;

   always #5 iclk = ~iclk;

   conv_acc_relu #(
      .pDATA_W (DW),
      .pCH_NUM (CH),
      .pACC_W  (AW)
   ) dut (
      .iclk   (iclk),
      .irst   (irst),
      .iclear (iclear),
      .ivalid (ivalid),
      .iready (iready),
      .idata  (idata),
      .ibias  (ibias),
      .ishift (ishift),
      .ovalid (ovalid),
      .oready (oready),
      .odata  (odata),
      .oclip  (oclip)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   // Scoreboard monitor: every completed handshake pops one expected result.
   always @(negedge iclk) begin : monitor
      logic [8:0] e;
      if (!irst && ovalid && oready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_result: got odata %0d oclip %0d, required no result", odata, oclip);
         end else begin
            e = exp_q.pop_front();
            chk("sb_odata", 32'(odata), 32'(e[7:0]));
            chk("sb_oclip", 32'(oclip), 32'(e[8]));
         end
      end
   end

   task automatic send_beat(input int d, input int b, input int s);
      int t = 0;
      while (!iready && t < 50) begin
         @(posedge iclk); #1;
         t++;
      end
      if (!iready) begin
         n_chk++;
         $display("FAIL beat_timeout: iready 0 after %0d cycles, required 1", t);
      end
      ivalid = 1'b1;
      idata  = 16'(d);
      ibias  = 32'(b);
      ishift = 5'(s);
      @(posedge iclk); #1;
      ivalid = 1'b0;
   endtask

   task automatic send_group(input int d, input int b, input int s);
      for (int i = 0; i < int'(CH); i++) send_beat(d, b, s);
   endtask

   task automatic wait_ovalid();
      int t = 0;
      do begin
         @(negedge iclk);
         t++;
      end while (!ovalid && t < 20);
      if (!ovalid) begin
         n_chk++;
         $display("FAIL ovalid_timeout: ovalid 0 after %0d cycles, required 1", t);
      end
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 50) begin
         @(posedge iclk); #1;
         t++;
      end
   endtask

   initial begin
      irst = 1'b1; iclear = 1'b0; ivalid = 1'b0; oready = 1'b1;
      idata = '0; ibias = '0; ishift = '0;
      repeat (2) @(negedge iclk);
      chk("rst_ovalid", 32'(ovalid), 0);
      chk("rst_odata",  32'(odata),  0);
      chk("rst_oclip",  32'(oclip),  0);
      @(posedge iclk); #1;
      irst = 1'b0;
      @(negedge iclk);
      chk("rst_iready", 32'(iready), 1);

      // 10+20+30+40 + rnd 2 = 102 >> 2 = 25, valid three cycles after last beat
      exp_q.push_back({1'b0, 8'd25});
      send_beat(10, 0, 2); send_beat(20, 0, 2); send_beat(30, 0, 2); send_beat(40, 0, 2);
      @(negedge iclk); chk("lat_c1", 32'(ovalid), 0);
      @(negedge iclk); chk("lat_c2", 32'(ovalid), 0);
      @(negedge iclk); chk("lat_c3", 32'(ovalid), 1);

      exp_q.push_back({1'b0, 8'd0});
      send_group(-50, 10, 0);
      exp_q.push_back({1'b1, 8'd255});
      send_group(1000, 0, 0);
      drain();

      // Backpressure: 3 x4 = 12 held while oready is low
      oready = 1'b0;
      exp_q.push_back({1'b0, 8'd12});
      send_group(3, 0, 0);
      wait_ovalid();
      for (int i = 0; i < 5; i++) begin
         @(negedge iclk);
         chk("hold_ovalid", 32'(ovalid), 1);
         chk("hold_odata",  32'(odata),  12);
         chk("hold_oclip",  32'(oclip),  0);
         chk("hold_iready", 32'(iready), 0);
      end
      @(posedge iclk); #1;
      oready = 1'b1;
      @(negedge iclk);
      @(negedge iclk);
      chk("hs_iready", 32'(iready), 1);
      chk("hs_ovalid", 32'(ovalid), 0);

      // Partial group aborted; the beat alongside iclear must not count
      send_beat(7, 0, 3); send_beat(7, 0, 3);
      iclear = 1'b1; ivalid = 1'b1; idata = 16'(100); ishift = 5'd3;
      @(posedge iclk); #1;
      iclear = 1'b0; ivalid = 1'b0;
      @(negedge iclk);
      chk("clr_iready", 32'(iready), 1);
      chk("clr_ovalid", 32'(ovalid), 0);
      exp_q.push_back({1'b0, 8'd4});
      send_group(1, 0, 0);
      drain();

      // Reset while holding a result: nothing emitted for that group
      oready = 1'b0;
      send_group(8, 0, 0);
      wait_ovalid();
      #2 irst = 1'b1;
      #1;
      chk("hrst_ovalid", 32'(ovalid), 0);
      chk("hrst_odata",  32'(odata),  0);
      chk("hrst_oclip",  32'(oclip),  0);
      @(posedge iclk); #1;
      irst = 1'b0;
      oready = 1'b1;
      @(negedge iclk);
      chk("hrst_iready", 32'(iready), 1);
      exp_q.push_back({1'b0, 8'd20});
      send_group(5, 0, 0);
      drain();
      repeat (3) @(negedge iclk);
      chk("sb_empty", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/conv_acc_relu.md
CONV_ACC_RELU -- requirements
Module: conv_acc_relu

Interface
REQ-001 The block SHALL have one clock, iclk, and a reset, irst, that is asynchronous and active-high.
REQ-002 Parameter pDATA_W SHALL default to 8 and set the activation width; each input partial sum SHALL be 2*pDATA_W bits wide.
REQ-003 Parameter pCH_NUM SHALL default to 16 and set the number of partial sums accumulated per output.
REQ-004 Parameter pACC_W SHALL default to 32 and set the signed accumulator width.
REQ-005 The ports SHALL be:
- iclk  in  1  clock.
- irst  in  1  async active-high reset.
- iclear  in  1  synchronous abort of the current group.
- ivalid  in  1  partial sum valid.
- iready  out  1  block accepts a partial sum this cycle.
- idata  in  2*pDATA_W  signed partial sum from the adder tree.
- ibias  in  pACC_W  signed bias, sampled with the first beat of a group.
- ishift  in  5  requant right-shift, sampled with the first beat of a group.
- ovalid  out  1  result valid.
- oready  in  1  downstream accepts the result.
- odata  out  pDATA_W  unsigned activation.
- oclip  out  1  result was clamped high; qualified by ovalid.

Function
REQ-006 The state machine SHALL have four states: ACC, BIAS, QUANT and HOLD; reset state SHALL be ACC.
REQ-007 A beat SHALL be accepted when ivalid and iready are both high; iready SHALL be high only in ACC.
REQ-008 In ACC:
- acc SHALL become the sign-extended idata on beat 0, and acc+idata on later beats.
- A beat counter SHALL count 0..pCH_NUM-1.
- On the accepted beat with count pCH_NUM-1, the counter SHALL wrap to 0 and the state SHALL go to BIAS.
REQ-009 Accumulation SHALL saturate at the signed pACC_W limits and SHALL NOT wrap.
REQ-010 BIAS SHALL take one cycle: acc = sat(acc + bias + rnd), where rnd = 1<<(shift-1) if shift>0, else 0; next state QUANT.
REQ-011 QUANT SHALL take one cycle: arithmetic right shift by the latched shift, then clamp:
- A result below 0 SHALL give 0.
- A result above 2^pDATA_W-1 SHALL give 2^pDATA_W-1 with oclip set.
- Next state SHALL be HOLD.
REQ-012 In HOLD, ovalid SHALL be 1 and odata/oclip SHALL stay stable until oready is high; the handshake cycle SHALL return the state to ACC.
REQ-013 Latency SHALL be ovalid high 3 cycles after the last beat is accepted; minimum spacing SHALL be pCH_NUM+3 cycles per result.
REQ-014 iclear SHALL act as follows:
- From any state, it SHALL force ACC, count 0, acc 0, ovalid 0 and oclip 0 on the next edge.
- An ivalid beat presented in the same cycle SHALL be discarded.
- iclear coincident with an ovalid/oready handshake SHALL still count the handshake as complete.
REQ-015 The first beat of each group SHALL latch ibias and ishift; values on later beats SHALL be ignored.
REQ-016 With ivalid low in ACC, acc and count SHALL hold.

Reset
REQ-017 Asserting irst SHALL set:
- ovalid 0, odata 0, oclip 0.
- acc 0, count 0.
- latched bias and shift to 0.
- state to ACC.
REQ-018 iready SHALL be high in the first cycle after irst deasserts.
REQ-019 Reset asserted mid-group or in HOLD SHALL discard all partial state; no result SHALL be emitted for that group.

Structure
REQ-020 The state enum and the saturation-limit constants SHALL live in the shared package conv_pkg.
REQ-021 The shift/ReLU/clamp logic SHALL be a combinational sub-module relu_requant, instantiated once.

Verification
REQ-022 The bench SHALL run with pCH_NUM=4, pDATA_W=8 and cover these directed scenarios:
- Beats 10,20,30,40, bias 0, shift 2 -> 100+2=102>>2 -> odata 25, oclip 0, ovalid 3 cycles after beat 4.
- Beats -50 x4, bias 10, shift 0 -> -190 -> odata 0, oclip 0.
- Beats 1000 x4, bias 0, shift 0 -> odata 255, oclip 1.
- Result ready, oready low for 5 cycles -> ovalid, odata and oclip stable, iready 0 throughout; handshake -> iready 1 on the next cycle.
- 2 beats of 7, then iclear with a coincident beat, then beats 1,1,1,1 with shift 0 -> odata 4.
- irst pulsed in HOLD -> ovalid 0 immediately; the next group of 5,5,5,5 with shift 0 -> odata 20.
